// File: rtl/fpu_op_if.sv
// Request/response bundle between the FP issue stage, this responder and the external arithmetic unit.
// A request is presented with en held high while the responder is idle; the responder answers with
// a one-cycle ready pulse and y valid in that cycle. An external op gets a one-cycle ext_start with
// ext_op/ext_a/ext_b valid. Those fields stay stable until the unit answers with a one-cycle
// ext_valid carrying ext_y.
interface fpu_op_if;
    logic        en;
    logic [4:0]  ctl;
    logic [31:0] x1;
    logic [31:0] x2;
    logic [31:0] y;
    logic        ready;
    logic        ext_start;
    logic [4:0]  ext_op;
    logic [31:0] ext_a;
    logic [31:0] ext_b;
    logic [31:0] ext_y;
    logic        ext_valid;
    logic        err;

    modport slave (
        input  en, ctl, x1, x2, ext_y, ext_valid,
        output y, ready, ext_start, ext_op, ext_a, ext_b, err
    );

    modport master (
        output en, ctl, x1, x2, ext_y, ext_valid,
        input  y, ready, ext_start, ext_op, ext_a, ext_b, err
    );
endinterface

// File: rtl/fpu_op_responder.sv
// FPU request responder: sign/compare/halve ops are answered locally, arithmetic ops go to an external unit.
// Optional FPU_TIMEOUT_EN macro adds a WAIT watchdog that answers a quiet NaN with err after TIMEOUT cycles.
module fpu_op_responder #(
    parameter int TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst,
    fpu_op_if.slave    bus,
    output logic [1:0] o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_y;
    logic [4:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;

    logic        w_accept;
    logic        w_is_ext;
    logic [31:0] w_local_y;
    logic        w_leave_wait;

    // Operand classification. Denormals are flushed, so any exponent of zero counts as zero.
    logic       w_a_sign;
    logic       w_b_sign;
    logic       w_a_zero;
    logic       w_b_zero;
    logic       w_a_nan;
    logic       w_b_nan;
    logic       w_mag_lt;
    logic       w_mag_gt;
    logic       w_eq;
    logic       w_lt;
    logic [7:0] w_a_exp;

    assign w_a_exp  = bus.x1[30:23];
    assign w_a_sign = bus.x1[31];
    assign w_b_sign = bus.x2[31];
    assign w_a_zero = (bus.x1[30:23] == 8'h00);
    assign w_b_zero = (bus.x2[30:23] == 8'h00);
    assign w_a_nan  = (bus.x1[30:23] == 8'hFF) && (bus.x1[22:0] != 23'd0);
    assign w_b_nan  = (bus.x2[30:23] == 8'hFF) && (bus.x2[22:0] != 23'd0);
    assign w_mag_lt = (bus.x1[30:0] < bus.x2[30:0]);
    assign w_mag_gt = (bus.x1[30:0] > bus.x2[30:0]);

    always_comb begin
        w_is_ext = 1'b0;
        case (bus.ctl)
            5'd0, 5'd1, 5'd2, 5'd3, 5'd4,
            5'd6, 5'd7, 5'd8, 5'd17, 5'd18: w_is_ext = 1'b1;
            default:                        w_is_ext = 1'b0;
        endcase
    end

    always_comb begin
        w_eq = 1'b0;
        w_lt = 1'b0;
        if (!w_a_nan && !w_b_nan) begin
            w_eq = (w_a_zero && w_b_zero) || (bus.x1 == bus.x2);
            if (w_a_zero && w_b_zero) begin
                w_lt = 1'b0;
            end else if (w_a_zero) begin
                w_lt = !w_b_sign;
            end else if (w_b_zero) begin
                w_lt = w_a_sign;
            end else if (w_a_sign != w_b_sign) begin
                w_lt = w_a_sign;
            end else if (!w_a_sign) begin
                w_lt = w_mag_lt;
            end else begin
                w_lt = w_mag_gt;
            end
        end
    end

    // Illegal codes fall into the default arm and answer zero.
    always_comb begin
        w_local_y = 32'd0;
        case (bus.ctl)
            5'd5: begin
                if (w_a_exp == 8'hFF) begin
                    w_local_y = bus.x1;
                end else if (w_a_exp <= 8'd1) begin
                    w_local_y = {w_a_sign, 31'd0};
                end else begin
                    w_local_y = {w_a_sign, w_a_exp - 8'd1, bus.x1[22:0]};
                end
            end
            5'd9:    w_local_y = {31'd0, w_eq};
            5'd10:   w_local_y = {31'd0, w_lt | w_eq};
            5'd11:   w_local_y = {1'b0, bus.x1[30:0]};
            5'd12:   w_local_y = {~bus.x1[31], bus.x1[30:0]};
            5'd13:   w_local_y = {31'd0, !w_a_nan && w_a_zero};
            5'd14:   w_local_y = {31'd0, !w_a_nan && !w_a_zero && !w_a_sign};
            5'd15:   w_local_y = {31'd0, !w_a_nan && !w_a_zero && w_a_sign};
            5'd16:   w_local_y = {31'd0, w_lt};
            default: w_local_y = 32'd0;
        endcase
    end

    assign w_accept = (r_state == ST_IDLE) && bus.en;

`ifdef FPU_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_err;
    logic             w_tmo;

    assign w_tmo        = (r_cnt == CNT_W'(TIMEOUT - 1));
    assign w_leave_wait = (r_state == ST_WAIT) && (bus.ext_valid || w_tmo);

    // The counter sits at zero outside WAIT so every WAIT entry starts a fresh window.
    always_ff @(posedge clk) begin
        if (rst || (r_state != ST_WAIT)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_leave_wait) begin
            r_err <= !bus.ext_valid;
        end else if (r_state == ST_RESP) begin
            r_err <= 1'b0;
        end
    end

    assign bus.err = r_err && (r_state == ST_RESP);
`else
    assign w_leave_wait = (r_state == ST_WAIT) && bus.ext_valid;
    assign bus.err      = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.en) begin
                    w_next = w_is_ext ? ST_ISSUE : ST_RESP;
                end
            end
            ST_ISSUE: w_next = ST_WAIT;
            ST_WAIT: begin
                if (w_leave_wait) begin
                    w_next = ST_RESP;
                end
            end
            ST_RESP:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_y     <= 32'd0;
            r_op    <= 5'd0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_op <= bus.ctl;
                r_a  <= bus.x1;
                r_b  <= bus.x2;
                if (!w_is_ext) begin
                    r_y <= w_local_y;
                end
            end
            if (w_leave_wait) begin
                r_y <= bus.ext_valid ? bus.ext_y : 32'h7FC0_0000;
            end
        end
    end

    assign bus.y         = r_y;
    assign bus.ready     = (r_state == ST_RESP);
    assign bus.ext_start = (r_state == ST_ISSUE);
    assign bus.ext_op    = r_op;
    assign bus.ext_a     = r_a;
    assign bus.ext_b     = r_b;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_fpu_op_responder.sv
// Randomised bench for fpu_op_responder: reference model of the FP op rules plus an expected-result queue.
// Build with FPU_TIMEOUT_EN defined to exercise the WAIT watchdog (TIMEOUT=8).
module tb_fpu_op_responder;

`ifdef FPU_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 64;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    fpu_op_if bus ();

    fpu_op_responder #(.TIMEOUT(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    logic [31:0] exp_q[$];
    logic [31:0] exp_err_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int n_ready  = 0;
    int n_start  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: floats ordered by a signed integer key, zero/denormal collapse to key 0.
    function automatic longint fkey(input logic [31:0] x);
        if (x[30:23] == 8'h00) return 0;
        return x[31] ? -longint'({1'b0, x[30:0]}) : longint'({1'b0, x[30:0]});
    endfunction

    function automatic bit is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    function automatic bit is_ext(input logic [4:0] c);
        return c inside {5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd6, 5'd7, 5'd8, 5'd17, 5'd18};
    endfunction

    function automatic logic [31:0] model_y(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
        longint ka = fkey(a);
        longint kb = fkey(b);
        bit     ok = !is_nan(a) && !is_nan(b);
        case (c)
            5'd5: begin
                if (a[30:23] == 8'hFF) return a;
                if (a[30:23] <= 8'd1) return a & 32'h8000_0000;
                return a - 32'h0080_0000;
            end
            5'd9:    return {31'd0, ok && (ka == kb)};
            5'd10:   return {31'd0, ok && (ka <= kb)};
            5'd16:   return {31'd0, ok && (ka < kb)};
            5'd11:   return a & 32'h7FFF_FFFF;
            5'd12:   return a ^ 32'h8000_0000;
            5'd13:   return {31'd0, !is_nan(a) && (ka == 0)};
            5'd14:   return {31'd0, !is_nan(a) && (ka > 0)};
            5'd15:   return {31'd0, !is_nan(a) && (ka < 0)};
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        logic [31:0] r = $urandom;
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return {r[31], 8'h00, r[22:0]};
            3:       return {r[31], 8'hFF, 23'd0};
            4:       return {r[31], 8'hFF, r[22:1], 1'b1};
            5:       return {r[31], 8'h01, r[22:0]};
            default: return r;
        endcase
    endfunction

    // Scoreboard: every ready pulse consumes exactly one expected response.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.ready) begin
                n_ready++;
                if (exp_q.size() == 0) begin
                    check_eq("spurious_ready", {31'd0, bus.ready}, 32'd0);
                end else begin
                    check_eq("resp_y", bus.y, exp_q.pop_front());
                    check_eq("resp_err", {31'd0, bus.err}, exp_err_q.pop_front());
                end
            end
            if (bus.ext_start) n_start++;
        end
    end

    // All driver tasks start and end on a falling edge.
    task automatic local_op(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
        int r0 = n_ready;
        int s0 = n_start;
        bus.en = 1'b1; bus.ctl = c; bus.x1 = a; bus.x2 = b;
        exp_q.push_back(model_y(c, a, b));
        exp_err_q.push_back(32'd0);
        @(negedge clk);
        bus.en = 1'b0;
        check_eq("local_ready_now", {31'd0, bus.ready}, 32'd1);
        @(negedge clk);
        check_eq("local_ready_cnt", n_ready - r0, 1);
        check_eq("local_no_start", n_start - s0, 0);
    endtask

    task automatic ext_op(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ey, input int delay, input bit extra_en, input bit early_valid);
        int r0 = n_ready;
        int s0 = n_start;
        bus.en = 1'b1; bus.ctl = c; bus.x1 = a; bus.x2 = b;
        exp_q.push_back(ey);
        exp_err_q.push_back(32'd0);
        @(negedge clk);
        bus.en = 1'b0;
        check_eq("ext_start", {31'd0, bus.ext_start}, 32'd1);
        check_eq("ext_op", {27'd0, bus.ext_op}, {27'd0, c});
        check_eq("ext_a", bus.ext_a, a);
        check_eq("ext_b", bus.ext_b, b);
        if (early_valid) begin
            bus.ext_valid = 1'b1; bus.ext_y = ~ey;
        end
        for (int i = 0; i <= delay; i++) begin
            @(negedge clk);
            bus.ext_valid = 1'b0;
            bus.en = 1'b0;
            if (extra_en && i == 0) begin
                bus.en = 1'b1; bus.ctl = 5'd12; bus.x1 = ~a; bus.x2 = ~b;
            end
            check_eq("wait_no_ready", {31'd0, bus.ready}, 32'd0);
            check_eq("wait_op_stable", {27'd0, bus.ext_op}, {27'd0, c});
            check_eq("wait_a_stable", bus.ext_a, a);
            check_eq("wait_b_stable", bus.ext_b, b);
        end
        bus.en = 1'b0;
        bus.ext_valid = 1'b1; bus.ext_y = ey;
        @(negedge clk);
        bus.ext_valid = 1'b0; bus.ext_y = $urandom;
        @(negedge clk);
        check_eq("ext_ready_cnt", n_ready - r0, 1);
        check_eq("ext_start_cnt", n_start - s0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        int r0;
        logic [4:0]  c;
        logic [31:0] a;
        logic [31:0] b;

        rst = 1'b1;
        bus.en = 1'b0; bus.ctl = 5'd0; bus.x1 = 32'd0; bus.x2 = 32'd0;
        bus.ext_valid = 1'b0; bus.ext_y = 32'd0;
        repeat (3) @(negedge clk);
        check_eq("rst_y", bus.y, 32'd0);
        check_eq("rst_ready", {31'd0, bus.ready}, 32'd0);
        check_eq("rst_ext_start", {31'd0, bus.ext_start}, 32'd0);
        check_eq("rst_ext_op", {27'd0, bus.ext_op}, 32'd0);
        check_eq("rst_ext_a", bus.ext_a, 32'd0);
        check_eq("rst_ext_b", bus.ext_b, 32'd0);
        check_eq("rst_err", {31'd0, bus.err}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        local_op(5'd12, 32'h3F80_0000, 32'd0);
        check_eq("fneg_one", bus.y, 32'hBF80_0000);
        local_op(5'd9, 32'h0000_0000, 32'h8000_0000);
        check_eq("feq_zeros", bus.y, 32'd1);
        local_op(5'd16, 32'h0000_0000, 32'h8000_0000);
        check_eq("fless_zeros", bus.y, 32'd0);
        local_op(5'd5, 32'h0080_0000, 32'd0);
        check_eq("fhalf_exp1", bus.y, 32'd0);
        local_op(5'd5, 32'h4000_0000, 32'd0);
        check_eq("fhalf_two", bus.y, 32'h3F80_0000);
        local_op(5'd9, 32'h7FC0_0000, 32'h7FC0_0000);
        check_eq("feq_nan", bus.y, 32'd0);
        local_op(5'd25, 32'h1234_5678, 32'h9ABC_DEF0);
        check_eq("illegal_zero", bus.y, 32'd0);

        ext_op(5'd0, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 2, 1'b1, 1'b0);
        check_eq("fadd_result", bus.y, 32'h4000_0000);
        ext_op(5'd4, 32'h4040_0000, 32'h4000_0000, 32'h3FC0_0000, 1, 1'b0, 1'b1);
        check_eq("fdiv_early_valid", bus.y, 32'h3FC0_0000);

        // Reset while waiting on the external unit; the late result must be dropped.
        r0 = n_ready;
        bus.en = 1'b1; bus.ctl = 5'd2; bus.x1 = 32'h4000_0000; bus.x2 = 32'h4040_0000;
        @(negedge clk);
        bus.en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("midrst_ready", {31'd0, bus.ready}, 32'd0);
        check_eq("midrst_y", bus.y, 32'd0);
        check_eq("midrst_ext_op", {27'd0, bus.ext_op}, 32'd0);
        check_eq("midrst_ext_a", bus.ext_a, 32'd0);
        bus.ext_valid = 1'b1; bus.ext_y = 32'h40C0_0000;
        @(negedge clk);
        bus.ext_valid = 1'b0;
        check_eq("late_valid_ready", {31'd0, bus.ready}, 32'd0);
        @(negedge clk);
        check_eq("late_valid_cnt", n_ready - r0, 0);
        local_op(5'd11, 32'hC000_0000, 32'd0);
        check_eq("after_rst_fabs", bus.y, 32'h4000_0000);

`ifdef FPU_TIMEOUT_EN
        r0 = n_ready;
        bus.en = 1'b1; bus.ctl = 5'd2; bus.x1 = 32'h3F80_0000; bus.x2 = 32'h3F80_0000;
        exp_q.push_back(32'h7FC0_0000);
        exp_err_q.push_back(32'd1);
        @(negedge clk);
        bus.en = 1'b0;
        repeat (TMO) begin
            @(negedge clk);
            check_eq("tmo_not_yet", {31'd0, bus.ready}, 32'd0);
        end
        @(negedge clk);
        check_eq("tmo_y", bus.y, 32'h7FC0_0000);
        check_eq("tmo_err", {31'd0, bus.err}, 32'd1);
        @(negedge clk);
        check_eq("tmo_ready_cnt", n_ready - r0, 1);
        ext_op(5'd2, 32'h4000_0000, 32'h4000_0000, 32'h4080_0000, TMO - 1, 1'b0, 1'b0);
        check_eq("tmo_valid_wins", bus.y, 32'h4080_0000);
`else
        r0 = n_ready;
        bus.en = 1'b1; bus.ctl = 5'd2; bus.x1 = 32'h3F80_0000; bus.x2 = 32'h3F80_0000;
        @(negedge clk);
        bus.en = 1'b0;
        repeat (100) @(negedge clk);
        check_eq("no_timeout", n_ready - r0, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
`endif

        for (int i = 0; i < 80; i++) begin
            c = 5'($urandom_range(0, 31));
            a = pick_operand();
            case ($urandom_range(0, 3))
                0:       b = a;
                1:       b = a ^ 32'h8000_0000;
                default: b = pick_operand();
            endcase
            if (is_ext(c)) begin
                ext_op(c, a, b, $urandom, $urandom_range(1, 4), $urandom_range(0, 2) == 0,
                       $urandom_range(0, 3) == 0);
            end else begin
                local_op(c, a, b);
            end
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        check_eq("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
